// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores that drains into data memory whenever
// no load holds the memory port. Define STORE_FORWARD_EN to forward loads from the buffer.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   req_ready,
   output logic                   load_valid,
   output logic [DATA_W-1:0]      load_data,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_w_en,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addrMem [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              loadValid_q, loadValid_d;
   logic [DATA_W-1:0] loadData_q, loadData_d;
   logic              storeAcc, loadAcc, drain, loadReady;
   logic [DATA_W-1:0] loadResult;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

`ifdef STORE_FORWARD_EN
   assign loadReady = 1'b1;

   // Walk oldest to youngest so the youngest matching entry wins
   always_comb begin
      logic [PTR_W-1:0] idx;
      loadResult = mem_rdata;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addrMem[idx] == req_addr))
            loadResult = dataMem[idx];
      end
   end
`else
   assign loadReady  = empty;
   assign loadResult = mem_rdata;
`endif

   assign req_ready  = !rst && (req_we ? !full : loadReady);
   assign storeAcc   = req_valid && req_we && req_ready;
   assign loadAcc    = req_valid && !req_we && req_ready;
   assign drain      = !rst && !loadAcc && !empty;

   assign mem_w_en   = drain;
   assign mem_addr   = loadAcc ? req_addr : addrMem[head_q];
   assign mem_wdata  = dataMem[head_q];
   assign load_valid = loadValid_q && !rst;
   assign load_data  = loadData_q;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      loadValid_d = loadAcc;
      loadData_d  = loadData_q;
      if (drain)
         head_d = head_q + PTR_W'(1);
      if (storeAcc)
         tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(storeAcc) - CNT_W'(drain);
      if (loadAcc)
         loadData_d = loadResult;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         loadValid_q <= 1'b0;
         loadData_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         loadValid_q <= loadValid_d;
         loadData_q  <= loadData_d;
      end
   end

   // Entry storage needs no reset: occupancy is tracked by count and the pointers
   always_ff @(posedge clk) begin
      if (storeAcc) begin
         addrMem[tail_q] <= req_addr;
         dataMem[tail_q] <= req_wdata;
      end
   end
endmodule
